sw_capture: RTL and testbench
=============================

SW_CAPTURE -- requirements
Module: sw_capture

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable synchronized samples required before the strobe level is accepted (range 1..255).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning number of captured entries held (power of two, >= 2).
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1, a reset that is asynchronous and active-low.
REQ-005 The block SHALL have port io_sw_i, input, 32, raw switch bank: bit 16 = entry strobe, bits 15:0 = signed value, bits 31:17 ignored.
REQ-006 The block SHALL have port rd_en_i, input, 1, processor pop request for the head entry.
REQ-007 The block SHALL have port clr_ovf_i, input, 1, which clears the overflow flag.
REQ-008 The block SHALL have port data_o, output, 32, the sign-extended head entry (first-word fall-through).
REQ-009 The block SHALL have port valid_o, output, 1, which is high when the FIFO is non-empty.
REQ-010 The block SHALL have port count_o, output, $clog2(FIFO_DEPTH)+1, the number of stored entries.
REQ-011 The block SHALL have port overflow_o, output, 1, a sticky flag indicating a capture was dropped.

Function
REQ-012 io_sw_i[16:0] SHALL pass through a 2-flop synchronizer; no other logic SHALL sample io_sw_i directly.
REQ-013 A debounce counter SHALL increment each cycle the synchronized strobe differs from the registered strobe level and SHALL clear to 0 whenever they are equal.
REQ-014 When the counter equals DEBOUNCE_CYCLES-1 and the inputs still differ, the strobe level SHALL flip at that edge and the counter SHALL clear.
REQ-015 A 0->1 flip of the strobe level SHALL push {16{sw[15]}, sw[15:0]} at that same edge, where sw is the synchronized value; 1->0 flips SHALL push nothing.
REQ-016 Latency: for io_sw_i stable from before edge 0, valid_o SHALL rise after edge DEBOUNCE_CYCLES+2 (edge 6 at default).
REQ-017 An input that holds its level (repeated identical words with bit 16 high) SHALL produce exactly one capture.
REQ-018 data_o SHALL show the oldest entry whenever valid_o=1, and SHALL be 0 when the FIFO is empty.
REQ-019 rd_en_i with valid_o=1 SHALL pop at the edge; rd_en_i with valid_o=0 SHALL be ignored.
REQ-020 A push while full without a simultaneous pop SHALL drop the new value, leave the contents unchanged, and set overflow_o.
REQ-021 A simultaneous push and pop while full SHALL perform both, keep count_o=FIFO_DEPTH, and leave overflow_o unchanged.
REQ-022 A push into an empty FIFO with rd_en_i high SHALL perform the push only; the pop is ignored per REQ-019.
REQ-023 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 count_o SHALL track pushes minus pops exactly.
REQ-025 overflow_o SHALL clear on clr_ovf_i=1; if a drop occurs in the same cycle, set SHALL win.

Reset
REQ-026 rst_ni=0 SHALL asynchronously clear the synchronizer flops, strobe level, debounce counter, pointers, count_o, overflow_o, valid_o and data_o to 0.
REQ-027 Reset asserted mid-debounce or mid-operation SHALL discard all entries and the in-progress debounce.
REQ-028 After release, a strobe already high SHALL be captured once (the strobe level resets to 0).

Configuration
REQ-029 With macro SW_CAPTURE_DEBOUNCE_EN defined, the debounce filter of REQ-013/REQ-014 SHALL be present.
REQ-030 With SW_CAPTURE_DEBOUNCE_EN undefined, the strobe level SHALL load the synchronized strobe every cycle, DEBOUNCE_CYCLES SHALL be ignored, and valid_o SHALL rise after edge 3 per REQ-016.

Verification (defaults, SW_CAPTURE_DEBOUNCE_EN defined)
REQ-031 Hold reset, drive io_sw_i=0x0001005D, release -> valid_o=1 after edge 6, data_o=0x0000005D, count_o=1; the word held for 12 more cycles adds no entry.
REQ-032 Drive io_sw_i[16] toggling every cycle for 20 cycles, low[15:0]=0x1234 -> no capture, count_o unchanged.
REQ-033 Enter 93, -346, -88, -493, 26, -257 (strobe high ~12 cycles, low ~12 cycles each) with no reads -> FIFO holds 0x0000005D, 0xFFFFFEA6, 0xFFFFFFA8, 0xFFFFFE13; overflow_o=1; count_o=4.
REQ-034 With the FIFO full, pulse rd_en_i on the capture edge of 26 -> count_o stays 4, overflow_o=0, head becomes 0xFFFFFEA6, tail is 0x0000001A.
REQ-035 With the FIFO empty, pulse rd_en_i -> count_o=0, data_o=0, valid_o=0; pulse clr_ovf_i after REQ-033 -> overflow_o=0.
REQ-036 With 2 entries and a debounce in progress, assert rst_ni=0 between clock edges -> count_o=0, valid_o=0, overflow_o=0 immediately, and no capture follows without a new strobe edge after release.

Source files
------------

// File: rtl/sw_capture.sv
// Switch-bank capture: synchronize, debounce the entry strobe, push sign-extended value into a FWFT FIFO.
// Define SW_CAPTURE_DEBOUNCE_EN to include the debounce filter; otherwise the strobe level follows the synchronizer.
module sw_capture #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [31:0]                   io_sw_i,
  input  logic                          rd_en_i,
  input  logic                          clr_ovf_i,
  output logic [31:0]                   data_o,
  output logic                          valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          overflow_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("sw_capture: illegal DEBOUNCE_CYCLES or FIFO_DEPTH");
  end

  function automatic logic signed [31:0] sign_ext(input logic signed [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // bits 31:17 of the switch bank carry nothing
  logic unused_hi;
  assign unused_hi = ^io_sw_i[31:17];

  logic [16:0] sync_p0, sync_p1;
  logic        strb_lvl;
  logic        strb_rise;

  // stage p0/p1: two-flop synchronizer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= io_sw_i[16:0];
      sync_p1 <= sync_p0;
    end
  end

`ifdef SW_CAPTURE_DEBOUNCE_EN
  logic [7:0] db_cnt;
  logic       db_done;

  assign db_done = (db_cnt == 8'(DEBOUNCE_CYCLES - 1));

  // strobe level only flips after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      strb_lvl <= 1'b0;
      db_cnt   <= '0;
    end else if (sync_p1[16] != strb_lvl) begin
      if (db_done) begin
        strb_lvl <= sync_p1[16];
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 8'd1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  assign strb_rise = sync_p1[16] && !strb_lvl && db_done;
`else
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) strb_lvl <= 1'b0;
    else         strb_lvl <= sync_p1[16];
  end

  assign strb_rise = sync_p1[16] && !strb_lvl;
`endif

  logic signed [31:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               ovf_q;
  logic               empty, full, do_pop, do_push, drop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign do_pop  = rd_en_i && !empty;
  // a full FIFO still accepts the push when the head leaves in the same cycle
  assign do_push = strb_rise && (!full || do_pop);
  assign drop    = strb_rise && full && !do_pop;

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= sign_ext($signed(sync_p1[15:0]));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      if (drop)           ovf_q <= 1'b1;
      else if (clr_ovf_i) ovf_q <= 1'b0;
    end
  end

  assign data_o     = empty ? 32'd0 : mem[rd_ptr];
  assign valid_o    = !empty;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_sw_capture.sv
// Directed bench for sw_capture at default parameters; latency follows SW_CAPTURE_DEBOUNCE_EN.
module tb_sw_capture;

`ifdef SW_CAPTURE_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] io_sw;
  logic        rd_en, clr_ovf;
  logic [31:0] data;
  logic        valid;
  logic [2:0]  count;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  sw_capture dut (
    .clk_i(clk), .rst_ni(rst_ni), .io_sw_i(io_sw), .rd_en_i(rd_en),
    .clr_ovf_i(clr_ovf), .data_o(data), .valid_o(valid),
    .count_o(count), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  task automatic enter_ctl(input logic [15:0] v, input logic rd, input logic clr);
    @(negedge clk);
    io_sw = {15'd0, 1'b1, v};
    repeat (LAT - 1) @(negedge clk);
    rd_en = rd; clr_ovf = clr;
    @(negedge clk);
    rd_en = 1'b0; clr_ovf = 1'b0;
    repeat (8) @(negedge clk);
    io_sw = 32'd0;
    repeat (12) @(negedge clk);
  endtask

  task automatic pop_one;
    @(negedge clk); rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
  endtask

  task automatic hard_reset;
    @(negedge clk); io_sw = 32'd0; rst_ni = 1'b0;
    @(negedge clk); rst_ni = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    io_sw = 32'h0001005D;
    repeat (2) @(negedge clk);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", valid); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", count); end
    total++; if (data !== 32'd0) begin bad++; $display("FAIL rst_data: got %h want 0", data); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_latency;
    rst_ni = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      total++;
      if (valid !== (k >= LAT)) begin bad++; $display("FAIL latency_edge%0d: got %b want %b", k, valid, (k >= LAT)); end
    end
    total++; if (data !== 32'h0000005D) begin bad++; $display("FAIL first_data: got %h want 0000005d", data); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL first_count: got %0d want 1", count); end
    repeat (12) @(negedge clk);
    total++; if (count !== 3'd1) begin bad++; $display("FAIL held_once: got %0d want 1", count); end
    io_sw = 32'd0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_empty_pop;
    pop_one();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL pop_count: got %0d want 0", count); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL pop_valid: got %b want 0", valid); end
    total++; if (data !== 32'd0) begin bad++; $display("FAIL pop_data: got %h want 0", data); end
    pop_one();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL empty_pop_count: got %0d want 0", count); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL empty_pop_valid: got %b want 0", valid); end
  endtask

  task automatic test_toggle;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      io_sw = {15'd0, (i % 2 == 0), 16'h1234};
    end
    @(negedge clk); io_sw = 32'd0;
    repeat (12) @(negedge clk);
`ifdef SW_CAPTURE_DEBOUNCE_EN
    total++; if (count !== 3'd0) begin bad++; $display("FAIL toggle_count: got %0d want 0", count); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL toggle_ovf: got %b want 0", ovf); end
`else
    total++; if (count !== 3'd4) begin bad++; $display("FAIL toggle_count: got %0d want 4", count); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL toggle_ovf: got %b want 1", ovf); end
`endif
    hard_reset();
  endtask

  task automatic test_overflow;
    enter_ctl(16'd93, 1'b0, 1'b0);
    enter_ctl(-16'sd346, 1'b0, 1'b0);
    enter_ctl(-16'sd88, 1'b0, 1'b0);
    enter_ctl(-16'sd493, 1'b0, 1'b0);
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL full_no_ovf: got %b want 0", ovf); end
    enter_ctl(16'd26, 1'b0, 1'b0);
    enter_ctl(-16'sd257, 1'b0, 1'b0);
    total++; if (count !== 3'd4) begin bad++; $display("FAIL ovf_count: got %0d want 4", count); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", ovf); end
    total++; if (data !== 32'h0000005D) begin bad++; $display("FAIL ovf_head: got %h want 0000005d", data); end
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", ovf); end
    enter_ctl(16'd77, 1'b0, 1'b1);
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL set_wins: got %b want 1", ovf); end
    total++; if (data !== 32'h0000005D) begin bad++; $display("FAIL drop_head: got %h want 0000005d", data); end
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    enter_ctl(16'd26, 1'b1, 1'b0);
    total++; if (count !== 3'd4) begin bad++; $display("FAIL pushpop_count: got %0d want 4", count); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL pushpop_ovf: got %b want 0", ovf); end
    total++; if (data !== 32'hFFFFFEA6) begin bad++; $display("FAIL pushpop_head: got %h want fffffea6", data); end
    pop_one();
    total++; if (data !== 32'hFFFFFFA8) begin bad++; $display("FAIL drain1: got %h want ffffffa8", data); end
    pop_one();
    total++; if (data !== 32'hFFFFFE13) begin bad++; $display("FAIL drain2: got %h want fffffe13", data); end
    pop_one();
    total++; if (data !== 32'h0000001A) begin bad++; $display("FAIL drain_tail: got %h want 0000001a", data); end
    pop_one();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL drain_count: got %0d want 0", count); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL drain_valid: got %b want 0", valid); end
  endtask

  task automatic test_reset_mid;
    enter_ctl(16'd5, 1'b0, 1'b0);
    enter_ctl(16'd6, 1'b0, 1'b0);
    total++; if (count !== 3'd2) begin bad++; $display("FAIL two_entries: got %0d want 2", count); end
    @(negedge clk); io_sw = 32'h00010007;
    repeat (LAT - 1) @(posedge clk);
    #2 rst_ni = 1'b0;
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL async_count: got %0d want 0", count); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL async_valid: got %b want 0", valid); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL async_ovf: got %b want 0", ovf); end
    total++; if (data !== 32'd0) begin bad++; $display("FAIL async_data: got %h want 0", data); end
    io_sw = 32'd0;
    @(negedge clk); rst_ni = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (count !== 3'd0) begin bad++; $display("FAIL post_rst_count: got %0d want 0", count); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL post_rst_valid: got %b want 0", valid); end
  endtask

  initial begin
    rst_ni = 1'b0; io_sw = 32'd0; rd_en = 1'b0; clr_ovf = 1'b0;
    test_reset();
    test_latency();
    test_empty_pop();
    test_toggle();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
